half_dot_accum: RTL and testbench

//  Half-precision (IEEE-754 binary16) dot-product accumulator: one neuron's pre-activation.

---
 rtl/half_dot_accum.sv | 212 +++++++++++++++++++++
 tb/tb_half_dot_accum.sv | 138 +++++++++++++
 2 files changed

// File: rtl/half_dot_accum.sv
// half_dot_accum: binary16 serial dot-product accumulator built from half_multiply and half_add.
// Define HALF_DOT_BIAS_EN to add a bias port whose value seeds the accumulator.
package half_fp_pkg;
   function automatic int expo(input logic [15:0] v);
      return (v[14:10] == 5'd0) ? 1 : int'(v[14:10]);
   endfunction
   function automatic logic [10:0] mant(input logic [15:0] v);
      return {|v[14:10], v[9:0]};
   endfunction
   function automatic logic is_nan(input logic [15:0] v);
      return (&v[14:10]) && (|v[9:0]);
   endfunction
   function automatic logic is_inf(input logic [15:0] v);
      return v[14:0] == 15'h7c00;
   endfunction
   function automatic logic is_zero(input logic [15:0] v);
      return v[14:0] == 15'd0;
   endfunction
   // Normalise, round to nearest even and pack; value = m / 2^21 * 2^(e-15)
   function automatic logic [15:0] pack(input logic s, input int e_in, input logic [21:0] m_in);
      int e;
      logic [21:0] m;
      logic st;
      logic [11:0] r;
      e = e_in;
      m = m_in;
      st = 1'b0;
      for (int i = 0; i < 22; i++)
         if (!m[21] && e > 1) begin
            m = m << 1;
            e = e - 1;
         end
      for (int i = 0; i < 23; i++)
         if (e < 1) begin
            st = st | m[0];
            m = m >> 1;
            e = e + 1;
         end
      r = {1'b0, m[21:11]} + 12'(m[10] & (st | (|m[9:0]) | m[11]));
      if (r[11]) begin
         r = r >> 1;
         e = e + 1;
      end
      return (m_in == 22'd0) ? {s, 15'd0} : (e >= 31) ? {s, 15'h7c00} : {s, r[10] ? e[4:0] : 5'd0, r[9:0]};
   endfunction
endpackage

module half_multiply (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   output logic [15:0] result
);
   import half_fp_pkg::*;
   logic [15:0] res_d, res_q;
   logic v_q, s;
   always_comb begin
      s = a[15] ^ b[15];
      res_d = (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) ? 16'h7e00 :
              (is_inf(a) || is_inf(b)) ? {s, 15'h7c00} :
              pack(s, expo(a) + expo(b) - 14, 22'(mant(a)) * 22'(mant(b)));
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         v_q <= 1'b0;
         res_q <= 16'h0000;
      end else begin
         v_q <= in_valid;
         if (in_valid) res_q <= res_d;
      end
   end
   assign out_valid = v_q;
   assign result = res_q;
endmodule

module half_add (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   output logic [15:0] result
);
   import half_fp_pkg::*;
   logic [15:0] res_d, res_q, l, sm;
   logic [20:0] ml, ms, sh;
   logic [21:0] mag;
   logic v_q, st, s;
   int d;
   always_comb begin
      l = (a[14:0] >= b[14:0]) ? a : b;
      sm = (a[14:0] >= b[14:0]) ? b : a;
      d = (expo(l) - expo(sm) > 21) ? 21 : expo(l) - expo(sm);
      ml = {mant(l), 10'd0};
      ms = {mant(sm), 10'd0};
      sh = ms >> d;
      st = |(ms & ((21'd1 << d) - 21'd1));
      // Bits shifted out of the smaller operand survive as a sticky LSB
      mag = (l[15] == sm[15]) ? {1'b0, ml} + {1'b0, sh | {20'd0, st}} : {1'b0, ml} - {1'b0, sh | {20'd0, st}};
      s = (mag == 22'd0) ? (a[15] & b[15]) : l[15];
      res_d = (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a[15] != b[15]))) ? 16'h7e00 :
              is_inf(a) ? a : is_inf(b) ? b : pack(s, expo(l) + 1, mag);
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         v_q <= 1'b0;
         res_q <= 16'h0000;
      end else begin
         v_q <= in_valid;
         if (in_valid) res_q <= res_d;
      end
   end
   assign out_valid = v_q;
   assign result = res_q;
endmodule

module half_dot_accum #(
   parameter int N_TERMS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x,
   input  logic [15:0] w,
`ifdef HALF_DOT_BIAS_EN
   input  logic [15:0] bias,
`endif
   output logic        out_valid,
   output logic [15:0] sum
);
   localparam int CW = $clog2(N_TERMS + 1);
   typedef enum logic [1:0] {IDLE, MUL_WAIT, ADD_WAIT, DONE} state_t;
   state_t state_q, state_d;
   logic [15:0] acc_q, acc_d, x_q, x_d, w_q, w_d, prod_q, prod_d, sum_q, sum_d, init, mul_res, add_res;
   logic [CW-1:0] cnt_q, cnt_d;
   logic mul_v_q, mul_v_d, add_v_q, add_v_d, mul_ov, add_ov, last;
`ifdef HALF_DOT_BIAS_EN
   assign init = bias;
`else
   assign init = 16'h0000;
`endif
   half_multiply u_mul (.clk(clk), .rstn(~rst), .in_valid(mul_v_q), .a(x_q), .b(w_q), .out_valid(mul_ov), .result(mul_res));
   half_add u_add (.clk(clk), .rstn(~rst), .in_valid(add_v_q), .a(acc_q), .b(prod_q), .out_valid(add_ov), .result(add_res));
   always_comb begin
      state_d = state_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      x_d = x_q;
      w_d = w_q;
      prod_d = prod_q;
      sum_d = sum_q;
      mul_v_d = 1'b0;
      add_v_d = 1'b0;
      last = cnt_q == CW'(N_TERMS - 1);
      case (state_q)
         IDLE: if (in_valid) begin
            x_d = x;
            w_d = w;
            mul_v_d = 1'b1;
            state_d = MUL_WAIT;
         end
         MUL_WAIT: if (mul_ov) begin
            prod_d = mul_res;
            add_v_d = 1'b1;
            state_d = ADD_WAIT;
         end
         ADD_WAIT: if (add_ov) begin
            acc_d = add_res;
            cnt_d = cnt_q + 1'b1;
            state_d = last ? DONE : IDLE;
         end
         DONE: begin
            sum_d = acc_q;
            acc_d = init;
            cnt_d = '0;
            state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q <= init;
         cnt_q <= '0;
         x_q <= 16'h0000;
         w_q <= 16'h0000;
         prod_q <= 16'h0000;
         sum_q <= 16'h0000;
         mul_v_q <= 1'b0;
         add_v_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         x_q <= x_d;
         w_q <= w_d;
         prod_q <= prod_d;
         sum_q <= sum_d;
         mul_v_q <= mul_v_d;
         add_v_q <= add_v_d;
      end
   end
   assign in_ready = state_q == IDLE;
   assign out_valid = state_q == DONE;
   // The result is presented during the DONE cycle and held afterwards
   assign sum = (state_q == DONE) ? acc_q : sum_q;
endmodule

// File: tb/tb_half_dot_accum.sv
// tb_half_dot_accum: scoreboard bench for half_dot_accum with N_TERMS=4.
// Build with HALF_DOT_BIAS_EN to exercise the bias variant.
module tb_half_dot_accum;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid;
   logic [15:0] x = 16'h0000, w = 16'h0000, sum;
`ifdef HALF_DOT_BIAS_EN
   logic [15:0] bias = 16'h3800;
`endif
   int checks = 0, failures = 0, cyc = 0, add_cyc = -10;
   logic [15:0] exp_q[$];
   logic [15:0] ws[4] = '{16'h3c00, 16'h4000, 16'h4200, 16'h4400};

   always #5 clk = ~clk;

   half_dot_accum #(.N_TERMS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
`ifdef HALF_DOT_BIAS_EN
      .bias(bias),
`endif
      .out_valid(out_valid), .sum(sum)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   initial forever begin
      @(negedge clk);
      cyc++;
      if (dut.u_add.out_valid) add_cyc = cyc;
      if (out_valid) begin
         check("latency", cyc - add_cyc, 1);
         check("ready_in_done", in_ready, 0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: sum=%h required=no output", sum);
         end else check("sum", sum, exp_q.pop_front());
      end
   end

   task automatic wait_ready(output int n);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic send(input logic [15:0] xv, input logic [15:0] wv, input int busy);
      int n;
      wait_ready(n);
      x = xv;
      w = wv;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_ready(n);
      check("busy_cycles", n, busy);
   endtask

   task automatic vec(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] e);
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++) send(xv, wv, (i == 3) ? 5 : 4);
      check("sum_hold", sum, e);
   endtask

   initial begin
      int n, acc_n, guard;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_sum", sum, 16'h0000);
`ifdef HALF_DOT_BIAS_EN
      vec(16'h3c00, 16'h4000, 16'h4840);
      vec(16'h3c00, 16'h4000, 16'h4840);
`else
      vec(16'h3c00, 16'h4000, 16'h4800);
      vec(16'h3c00, 16'hc000, 16'hc800);
      vec(16'h3e00, 16'h3e00, 16'h4880);
      vec(16'h7bff, 16'h4000, 16'h7c00);
      exp_q.push_back(16'h4000);
      send(16'h3c00, 16'h4000, 4);
      send(16'h3c00, 16'hc000, 4);
      send(16'h3c00, 16'h3c00, 4);
      send(16'h3c00, 16'h3c00, 5);
      // in_valid held high; junk pairs are presented whenever the block is busy
      exp_q.push_back(16'h4900);
      acc_n = 0;
      guard = 0;
      in_valid = 1'b1;
      while (acc_n < 4 && guard < 200) begin
         if (in_ready) begin
            x = 16'h3c00;
            w = ws[acc_n];
            acc_n++;
         end else begin
            x = 16'h4400 + 16'(guard);
            w = 16'h4400;
         end
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b0;
      wait_ready(n);
      check("held_valid_busy", n, 5);
      check("held_valid_sum", sum, 16'h4900);
      send(16'h3c00, 16'h4000, 4);
      send(16'h3c00, 16'h4000, 4);
      x = 16'h3c00;
      w = 16'h4000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready", in_ready, 1);
      check("midrst_valid", out_valid, 0);
      vec(16'h3c00, 16'h3c00, 16'h4400);
`endif
      repeat (10) @(negedge clk);
      check("pending_outputs", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
